// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predictor: direction-counter encodings
// and the default fetch increment.
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int INSTR_BYTES_DEF = 2;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter: moves one step toward the resolved
// direction and sticks at the strong states instead of wrapping.
module bp_sat_counter
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with 2-bit direction
// counters, trained from execute resolutions, with a registered flush/redirect.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         WIDTH       = 16,
  parameter int         IDX_BITS    = 4,
  parameter int         INSTR_BYTES = INSTR_BYTES_DEF,
  parameter logic [1:0] CTR_INIT    = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [WIDTH-1:0] fetch_PC,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic [WIDTH-1:0] next_PC,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_PC,
  input  logic             res_jump,
  input  logic             res_jumpreg,
  input  logic             res_taken,
  input  logic [WIDTH-1:0] res_target,
  input  logic             res_pred_taken,
  input  logic [WIDTH-1:0] res_pred_target,
  output logic             flush,
  output logic [WIDTH-1:0] redirect_PC,
  output logic [15:0]      mispredict_cnt
);

  localparam int               OFF     = $clog2(INSTR_BYTES);
  localparam int               ENTRIES = 1 << IDX_BITS;
  localparam int               TAG_W   = WIDTH - IDX_BITS - OFF;
  localparam logic [WIDTH-1:0] INC     = WIDTH'(INSTR_BYTES);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, r_idx;
  logic [TAG_W-1:0]    f_tag, r_tag;
  logic                f_hit, r_hit;
  logic [WIDTH-1:0]    fetch_seq;
  logic                actual_taken, mispredict;
  logic [WIDTH-1:0]    actual_next;
  logic [1:0]          ctr_nxt;

  // Direction alone is subsumed by the full next-PC comparison below.
  logic unused_res_pred_taken;
  assign unused_res_pred_taken = res_pred_taken;

  assign f_idx     = fetch_PC[IDX_BITS+OFF-1:OFF];
  assign f_tag     = fetch_PC[WIDTH-1:IDX_BITS+OFF];
  assign f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign fetch_seq = fetch_PC + INC;

  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = f_hit ? target_q[f_idx] : fetch_seq;
  assign next_PC     = pred_taken ? pred_target : fetch_seq;

  assign r_idx        = res_PC[IDX_BITS+OFF-1:OFF];
  assign r_tag        = res_PC[WIDTH-1:IDX_BITS+OFF];
  assign r_hit        = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign actual_taken = res_jump | res_taken;
  assign actual_next  = actual_taken ? res_target : (res_PC + INC);
  assign mispredict   = res_valid && (actual_next != res_pred_target);

  bp_sat_counter u_ctr (
    .cur   (ctr_q[r_idx]),
    .taken (actual_taken),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (res_valid && !stall) begin
      if (r_hit) begin
        ctr_q[r_idx] <= ctr_nxt;
        if (actual_taken) target_q[r_idx] <= res_target;
      end else if (actual_taken && !res_jumpreg) begin
        // Allocation overwrites whatever alias previously owned this index.
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= res_target;
        ctr_q[r_idx]    <= res_jump ? ST : WT;
      end
    end
  end

  // The counter advances in the same edge that registers each flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_PC    <= '0;
      mispredict_cnt <= '0;
    end else if (!stall) begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_PC <= actual_next;
        if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus random
// resolutions, all compared against an array-based behavioural predictor model.
module tb_branch_predict_unit;

  localparam int WIDTH = 16;
  localparam int IB    = 2;
  localparam int ENT   = 16;
  localparam int PCMOD = 65536;

  logic             clk;
  logic             rst;
  logic             stall;
  logic [WIDTH-1:0] fetch_PC;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;
  logic [WIDTH-1:0] next_PC;
  logic             res_valid;
  logic [WIDTH-1:0] res_PC;
  logic             res_jump;
  logic             res_jumpreg;
  logic             res_taken;
  logic [WIDTH-1:0] res_target;
  logic             res_pred_taken;
  logic [WIDTH-1:0] res_pred_target;
  logic             flush;
  logic [WIDTH-1:0] redirect_PC;
  logic [15:0]      mispredict_cnt;

  int vectors;
  int miscompares;

  int m_valid  [ENT];
  int m_tag    [ENT];
  int m_target [ENT];
  int m_ctr    [ENT];
  int m_flush, m_redirect, m_cnt;

  branch_predict_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .fetch_PC        (fetch_PC),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .next_PC         (next_PC),
    .res_valid       (res_valid),
    .res_PC          (res_PC),
    .res_jump        (res_jump),
    .res_jumpreg     (res_jumpreg),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .flush           (flush),
    .redirect_PC     (redirect_PC),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic int idx_of(int pc);
    return (pc / IB) % ENT;
  endfunction

  function automatic int tag_of(int pc);
    return pc / (IB * ENT);
  endfunction

  function automatic bit model_hit(int pc);
    return m_valid[idx_of(pc)] != 0 && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit model_ptaken(int pc);
    return model_hit(pc) && m_ctr[idx_of(pc)] >= 2;
  endfunction

  function automatic int model_ptarget(int pc);
    return model_hit(pc) ? m_target[idx_of(pc)] : (pc + IB) % PCMOD;
  endfunction

  function automatic int model_npc(int pc);
    return model_ptaken(pc) ? model_ptarget(pc) : (pc + IB) % PCMOD;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_flush = 0; m_redirect = 0; m_cnt = 0;
  endtask

  // One clock: check prediction before the edge, then registered state after it.
  task automatic applyStimulus(input int fpc, input bit v, input int pc, input bit jmp,
                               input bit jr, input bit tk, input int tgt, input int ppt,
                               input bit stl);
    bit at, mis;
    int an, i;
    @(negedge clk);
    fetch_PC = WIDTH'(fpc); stall = stl; res_valid = v; res_PC = WIDTH'(pc);
    res_jump = jmp; res_jumpreg = jr; res_taken = tk; res_target = WIDTH'(tgt);
    res_pred_target = WIDTH'(ppt); res_pred_taken = (ppt != (pc + IB) % PCMOD);
    #1;
    checkOutput("pred_taken", pred_taken, model_ptaken(fpc));
    checkOutput("pred_target", pred_target, model_ptarget(fpc));
    checkOutput("next_PC", next_PC, model_npc(fpc));
    at  = jmp | tk;
    an  = at ? tgt : (pc + IB) % PCMOD;
    mis = v && (an != ppt);
    @(posedge clk);
    if (!stl) begin
      m_flush = mis;
      if (mis) begin
        m_redirect = an;
        if (m_cnt < 65535) m_cnt++;
      end
      if (v) begin
        i = idx_of(pc);
        if (model_hit(pc)) begin
          m_ctr[i] = at ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
          if (at) m_target[i] = tgt;
        end else if (at && !jr) begin
          m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_ctr[i] = jmp ? 3 : 2;
        end
      end
    end
    #1;
    checkOutput("flush", flush, m_flush);
    checkOutput("redirect_PC", redirect_PC, m_redirect);
    checkOutput("mispredict_cnt", mispredict_cnt, m_cnt);
  endtask

  task automatic idle(input int fpc);
    applyStimulus(fpc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input int pc, input bit jmp, input bit jr, input bit tk,
                         input int tgt, input int ppt, input bit stl);
    applyStimulus(pc, 1, pc, jmp, jr, tk, tgt, ppt, stl);
  endtask

  task automatic doReset();
    res_valid = 0; stall = 0;
    rst = 1'b1;
    #2;
    model_clear();
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_redirect", redirect_PC, 0);
    checkOutput("rst_cnt", mispredict_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pc, tgt, ppt, guard;
    bit jmp, jr, tk, stl;
    vectors = 0; miscompares = 0;
    stall = 0; fetch_PC = 0; res_valid = 0; res_PC = 0; res_jump = 0; res_jumpreg = 0;
    res_taken = 0; res_target = 0; res_pred_taken = 0; res_pred_target = 0;
    model_clear();
    doReset();

    idle(16'h0040);
    checkOutput("tp_reset_pred", pred_taken, 0);
    checkOutput("tp_reset_next", next_PC, 16'h0042);

    resolve(16'h0040, 0, 0, 1, 16'h0100, 16'h0042, 0);
    checkOutput("tp_first_flush", flush, 1);
    checkOutput("tp_first_redirect", redirect_PC, 16'h0100);
    idle(16'h0040);
    checkOutput("tp_alloc_next", next_PC, 16'h0100);

    resolve(16'h0040, 0, 0, 0, 0, 16'h0100, 0);
    idle(16'h0040);
    checkOutput("tp_hyst_pred", pred_taken, 0);
    resolve(16'h0040, 0, 0, 0, 0, 16'h0042, 0);
    for (int k = 0; k < 4; k++) resolve(16'h0040, 0, 0, 1, 16'h0100, model_npc(16'h0040), 0);
    resolve(16'h0040, 0, 0, 0, 0, 16'h0100, 0);
    idle(16'h0040);
    checkOutput("tp_nowrap_pred", pred_taken, 1);

    resolve(16'h0060, 0, 0, 1, 16'h0300, 16'h0062, 0);
    idle(16'h0040);
    checkOutput("tp_alias_next", next_PC, 16'h0042);
    idle(16'h0060);

    resolve(16'h0080, 1, 1, 1, 16'h0200, 16'h0082, 0);
    checkOutput("tp_jr_redirect", redirect_PC, 16'h0200);
    idle(16'h0080);
    checkOutput("tp_jr_noalloc", next_PC, 16'h0082);
    resolve(16'h0060, 1, 1, 1, 16'h0400, 16'h0300, 0);
    idle(16'h0060);
    checkOutput("tp_jr_hit_target", next_PC, 16'h0400);

    resolve(16'h00A0, 0, 0, 1, 16'h0500, 16'h00A2, 1);
    checkOutput("tp_stall_flush", flush, 0);
    idle(16'h00A0);
    resolve(16'h00A0, 0, 0, 1, 16'h0500, 16'h00A2, 0);
    applyStimulus(16'h00A0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("tp_stall_hold", flush, 1);

    idle(16'hFFFE);
    checkOutput("tp_wrap_next", next_PC, 16'h0000);

    resolve(16'hFFFE, 0, 0, 0, 0, 16'h1234, 0);
    checkOutput("tp_wrap_redirect", redirect_PC, 16'h0000);
    resolve(16'h0020, 0, 0, 1, 16'h0700, 16'h0022, 0);
    doReset();
    idle(16'h0020);

    for (int n = 0; n < 400; n++) begin
      pc  = (n % 37 == 0) ? 16'hFFFC : $urandom_range(0, 95) * 2;
      jr  = ($urandom_range(0, 7) == 0);
      jmp = jr || ($urandom_range(0, 3) == 0);
      tk  = $urandom_range(0, 1);
      tgt = $urandom_range(0, 255) * 2;
      stl = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0, 1: ppt = model_npc(pc);
        2:    ppt = (pc + IB) % PCMOD;
        default: ppt = tgt;
      endcase
      applyStimulus($urandom_range(0, 95) * 2, $urandom_range(0, 3) != 0, pc, jmp, jr, tk,
                    tgt, ppt, stl);
    end

    guard = 0;
    while (m_cnt < 65535 && guard < 70000) begin
      resolve(16'h0080, 1, 1, 1, 16'h0200, 16'h0082, 0);
      guard++;
    end
    resolve(16'h0080, 1, 1, 1, 16'h0200, 16'h0082, 0);
    resolve(16'h0080, 1, 1, 1, 16'h0200, 16'h0082, 0);
    checkOutput("tp_cnt_saturate", mispredict_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
